// File: rtl/dpu_arb_pkg.sv
// Shared definitions for the DPU command-port arbiter: FSM states,
// core command-type encodings and the grant-index width helper.
package dpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_RSP
    } arb_state_t;

    // Command-type encodings understood by the DPU core.
    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_WR  = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpu_rr_picker.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping around the vector.
module dpu_rr_picker
    import dpu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dpu_cmd_arbiter.sv
// Round-robin arbiter sharing the DPU core's byte-wide PIO command port
// between requesters, with read-response routing, burst lock and read timeout.
module dpu_cmd_arbiter
    import dpu_arb_pkg::*;
#(
    parameter  int         NUM_REQ     = 3,
    parameter  int         ADDR_BITS   = 24,
    parameter  logic [2:0] RD_CMD      = CMD_RD,
    parameter  int         RSP_TIMEOUT = 255,
    localparam int         IW          = idx_width(NUM_REQ)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_lock,
    input  logic [NUM_REQ-1:0][2:0]           req_type,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQ-1:0][7:0]           req_data,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [7:0]                        rsp_data,
    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic [2:0]                        m_cmd_type,
    output logic [ADDR_BITS-1:0]              m_cmd_addr,
    output logic [7:0]                        m_cmd_data,
    input  logic                              m_rsp_valid,
    input  logic [7:0]                        m_rsp_data,
    output logic [IW-1:0]                     grant_id,
    output logic                              arb_busy,
    output logic                              timeout_err
);

    localparam int            TW         = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(RSP_TIMEOUT - 1);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [TW-1:0] timer;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          in_grant;
    logic          in_wait;
    logic          own_valid;
    logic          own_lock;
    logic          own_rd;
    logic          cmd_hs;
    logic          rsp_hit;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    dpu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_grant  = (state == GRANT);
    assign in_wait   = (state == WAIT_RSP);
    assign own_valid = req_valid[grant_id];
    assign own_lock  = req_lock[grant_id];
    assign own_rd    = (req_type[grant_id] == RD_CMD);

    assign m_cmd_valid = in_grant & own_valid;
    assign cmd_hs      = m_cmd_valid & m_cmd_ready;
    assign rsp_hit     = in_wait & m_rsp_valid;

    // A response arriving on the expiry cycle still counts, so it masks the timeout.
    assign timeout_err = in_wait & ~m_rsp_valid & (timer == TIMER_LAST);
    assign arb_busy    = (state != IDLE);
    assign rsp_data    = rsp_hit ? m_rsp_data : 8'h00;

    // Payload and ready are steered from the owner only while granted, so an
    // idle or waiting arbiter presents an all-zero command port.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        m_cmd_type = '0;
        m_cmd_addr = '0;
        m_cmd_data = '0;
        if (in_grant) begin
            req_ready[grant_id] = m_cmd_ready;
            m_cmd_type          = req_type[grant_id];
            m_cmd_addr          = req_addr[grant_id];
            m_cmd_data          = req_data[grant_id];
        end
        if (rsp_hit) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= '0;
            timer    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (cmd_hs) begin
                        if (own_rd) begin
                            state <= WAIT_RSP;
                            timer <= '0;
                        end else if (!own_lock) begin
                            state <= IDLE;
                            ptr   <= wrap_inc(grant_id);
                        end
                    end else if (!own_valid && !own_lock) begin
                        state <= IDLE;
                        ptr   <= wrap_inc(grant_id);
                    end
                end
                WAIT_RSP: begin
                    if (m_rsp_valid) begin
                        if (own_lock) begin
                            state <= GRANT;
                        end else begin
                            state <= IDLE;
                            ptr   <= wrap_inc(grant_id);
                        end
                    end else if (timer == TIMER_LAST) begin
                        state <= IDLE;
                        ptr   <= wrap_inc(grant_id);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpu_cmd_arbiter.sv
// Directed, scoreboard-based bench for dpu_cmd_arbiter.
module tb_dpu_cmd_arbiter;
    import dpu_arb_pkg::*;

    localparam int NUM_REQ     = 3;
    localparam int ADDR_BITS   = 24;
    localparam int RSP_TIMEOUT = 8;
    localparam int IW          = idx_width(NUM_REQ);

    logic                              aclk = 1'b0;
    logic                              aresetn;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_lock;
    logic [NUM_REQ-1:0][2:0]           req_type;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ-1:0][7:0]           req_data;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [7:0]                        rsp_data;
    logic                              m_cmd_valid;
    logic                              m_cmd_ready;
    logic [2:0]                        m_cmd_type;
    logic [ADDR_BITS-1:0]              m_cmd_addr;
    logic [7:0]                        m_cmd_data;
    logic                              m_rsp_valid;
    logic [7:0]                        m_rsp_data;
    logic [IW-1:0]                     grant_id;
    logic                              arb_busy;
    logic                              timeout_err;

    dpu_cmd_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_BITS   (ADDR_BITS),
        .RD_CMD      (CMD_RD),
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_lock    (req_lock),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_cmd_type  (m_cmd_type),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_data  (m_cmd_data),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [IW-1:0]        id;
        logic [2:0]           typ;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } cmd_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   hs_cyc[$];
    cmd_t mon_c;
    rsp_t mon_r;
    int   cyc     = 0;
    int   rsp_cnt = 0;
    int   to_cnt  = 0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input int id, input logic [2:0] t,
                                    input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
        cmd_t c;
        c.id   = IW'(id);
        c.typ  = t;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Scoreboard: every handshake and response strobe must match the next expectation.
    always @(negedge aclk) begin
        if (timeout_err) to_cnt++;
        if (m_cmd_valid && m_cmd_ready) begin
            hs_cyc.push_back(cyc);
            check("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
            if (cmd_q.size() != 0) begin
                mon_c = cmd_q.pop_front();
                check("hs_grant_id", 32'(grant_id), 32'(mon_c.id));
                check("hs_type", 32'(m_cmd_type), 32'(mon_c.typ));
                check("hs_addr", 32'(m_cmd_addr), 32'(mon_c.addr));
                check("hs_data", 32'(m_cmd_data), 32'(mon_c.data));
                check("hs_ready", 32'(req_ready), 32'd1 << mon_c.id);
            end
        end
        if (rsp_valid != '0) begin
            rsp_cnt++;
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                mon_r = rsp_q.pop_front();
                check("rsp_route", 32'(rsp_valid), 32'd1 << mon_r.id);
                check("rsp_byte", 32'(rsp_data), 32'(mon_r.data));
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
        #1;
    endtask

    task automatic wait_hs(input int n, input int budget);
        for (int i = 0; i < budget && hs_cyc.size() < n; i++) sample();
        check("wait_hs", 32'(hs_cyc.size() >= n), 32'd1);
    endtask

    task automatic outputs_zero(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({pfx, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({pfx, "_m_cmd_valid"}, 32'(m_cmd_valid), 32'd0);
        check({pfx, "_m_cmd_type"}, 32'(m_cmd_type), 32'd0);
        check({pfx, "_m_cmd_addr"}, 32'(m_cmd_addr), 32'd0);
        check({pfx, "_m_cmd_data"}, 32'(m_cmd_data), 32'd0);
        check({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
        check({pfx, "_arb_busy"}, 32'(arb_busy), 32'd0);
        check({pfx, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t_h;
        int t_to;
        bit seen;

        aresetn     = 1'b0;
        req_valid   = '0;
        req_lock    = '0;
        req_type    = '0;
        req_addr    = '0;
        req_data    = '0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;

        sample();
        outputs_zero("rst");
        tick();
        aresetn = 1'b1;

        // Round-robin: all three requesters valid with unlocked writes.
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_type[i] = CMD_WR;
            req_addr[i] = ADDR_BITS'(32'h100 + i);
            req_data[i] = 8'(32'h10 + i);
        end
        for (int k = 0; k < 6; k++)
            cmd_q.push_back(mk_cmd(k % 3, CMD_WR, ADDR_BITS'(32'h100 + k % 3), 8'(32'h10 + k % 3)));
        hs_cyc.delete();
        m_cmd_ready = 1'b1;
        req_valid   = '1;
        t0          = cyc;
        wait_hs(6, 40);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        check("rr_first_latency", 32'(hs_cyc[0] - t0), 32'd1);
        for (int k = 1; k < 6; k++) check("rr_gap", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd2);
        sample();
        check("rr_idle", 32'(arb_busy), 32'd0);

        // Single write from requester 1, core holding ready low for one cycle.
        tick();
        hs_cyc.delete();
        req_type[1] = CMD_WR;
        req_addr[1] = 24'h000123;
        req_data[1] = 8'hA5;
        req_valid   = 3'b010;
        cmd_q.push_back(mk_cmd(1, CMD_WR, 24'h000123, 8'hA5));
        sample();
        check("wr_arb_cycle_no_valid", 32'(m_cmd_valid), 32'd0);
        tick();
        sample();
        check("wr_valid", 32'(m_cmd_valid), 32'd1);
        check("wr_grant", 32'(grant_id), 32'd1);
        check("wr_addr", 32'(m_cmd_addr), 32'h000123);
        check("wr_data", 32'(m_cmd_data), 32'h0000A5);
        check("wr_ready_low", 32'(req_ready), 32'd0);
        tick();
        m_cmd_ready = 1'b1;
        sample();
        check("wr_ready_pulse", 32'(req_ready), 32'b010);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        sample();
        check("wr_back_idle", 32'(arb_busy), 32'd0);
        check("wr_one_hs", 32'(hs_cyc.size()), 32'd1);

        // Read from requester 2 answered 5 cycles after the handshake.
        tick();
        hs_cyc.delete();
        req_type[2] = CMD_RD;
        req_addr[2] = 24'h00ABCD;
        req_data[2] = 8'h00;
        req_valid   = 3'b100;
        m_cmd_ready = 1'b1;
        cmd_q.push_back(mk_cmd(2, CMD_RD, 24'h00ABCD, 8'h00));
        wait_hs(1, 10);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        sample();
        check("rd_wait_busy", 32'(arb_busy), 32'd1);
        check("rd_wait_no_cmd", 32'(m_cmd_valid), 32'd0);
        repeat (3) tick();
        tick();
        rsp_q.push_back(rsp_t'{id: IW'(2), data: 8'h3C});
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'h3C;
        sample();
        check("rd_rsp_cycle", 32'(cyc - hs_cyc[0]), 32'd5);
        check("rd_rsp_valid", 32'(rsp_valid), 32'b100);
        check("rd_rsp_data", 32'(rsp_data), 32'h3C);
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        sample();
        check("rd_rsp_single", 32'(rsp_valid), 32'd0);
        check("rd_back_idle", 32'(arb_busy), 32'd0);
        tick();
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'hEE;
        sample();
        check("stray_rsp_ignored", 32'(rsp_valid), 32'd0);
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;

        // Locked 16-beat burst from requester 1 while requester 0 waits.
        tick();
        hs_cyc.delete();
        req_type[1] = CMD_WR;
        req_addr[1] = 24'h000200;
        req_data[1] = 8'h00;
        req_lock    = 3'b010;
        req_valid   = 3'b010;
        m_cmd_ready = 1'b1;
        for (int k = 0; k < 16; k++) cmd_q.push_back(mk_cmd(1, CMD_WR, 24'h000200, 8'(k)));
        cmd_q.push_back(mk_cmd(0, CMD_WR, 24'h000055, 8'h77));
        tick();
        req_type[0] = CMD_WR;
        req_addr[0] = 24'h000055;
        req_data[0] = 8'h77;
        req_valid   = 3'b011;
        for (int k = 1; k < 16; k++) begin
            tick();
            req_data[1] = 8'(k);
            if (k == 15) req_lock = 3'b000;
        end
        tick();
        req_valid = 3'b001;
        wait_hs(17, 10);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        for (int k = 1; k < 16; k++) check("lock_back_to_back", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd1);
        check("lock_release_gap", 32'(hs_cyc[16] - hs_cyc[15]), 32'd2);

        // Read from requester 2 with no response; requester 0 queued behind it.
        tick();
        hs_cyc.delete();
        to_cnt      = 0;
        req_type[2] = CMD_RD;
        req_addr[2] = 24'h000300;
        req_type[0] = CMD_WR;
        req_addr[0] = 24'h000066;
        req_data[0] = 8'h11;
        req_valid   = 3'b101;
        m_cmd_ready = 1'b1;
        cmd_q.push_back(mk_cmd(2, CMD_RD, 24'h000300, 8'h00));
        cmd_q.push_back(mk_cmd(0, CMD_WR, 24'h000066, 8'h11));
        wait_hs(1, 10);
        t_h = hs_cyc[0];
        tick();
        req_valid = 3'b001;
        seen = 1'b0;
        t_to = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (timeout_err) begin
                seen = 1'b1;
                t_to = cyc;
                check("to_no_rsp", 32'(rsp_valid), 32'd0);
            end
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_delay", 32'(t_to - t_h), 32'(RSP_TIMEOUT));
        wait_hs(2, 10);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        check("to_pulse_count", 32'(to_cnt), 32'd1);
        check("to_next_grant_gap", 32'(hs_cyc[1] - t_to), 32'd2);

        // Response landing on the expiry cycle wins over the timeout.
        tick();
        hs_cyc.delete();
        req_type[1] = CMD_RD;
        req_addr[1] = 24'h000400;
        req_data[1] = 8'h00;
        req_valid   = 3'b010;
        m_cmd_ready = 1'b1;
        cmd_q.push_back(mk_cmd(1, CMD_RD, 24'h000400, 8'h00));
        wait_hs(1, 10);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        for (int i = 0; i < 20 && cyc < hs_cyc[0] + RSP_TIMEOUT; i++) tick();
        rsp_q.push_back(rsp_t'{id: IW'(1), data: 8'h5A});
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'h5A;
        sample();
        check("tie_no_timeout", 32'(timeout_err), 32'd0);
        check("tie_rsp_valid", 32'(rsp_valid), 32'b010);
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        sample();
        check("tie_back_idle", 32'(arb_busy), 32'd0);

        // Asynchronous reset while requester 1 waits for read data.
        tick();
        hs_cyc.delete();
        req_type[1] = CMD_RD;
        req_addr[1] = 24'h000500;
        req_valid   = 3'b010;
        m_cmd_ready = 1'b1;
        cmd_q.push_back(mk_cmd(1, CMD_RD, 24'h000500, 8'h00));
        wait_hs(1, 10);
        tick();
        req_valid   = '0;
        m_cmd_ready = 1'b0;
        sample();
        check("ar_busy_before", 32'(arb_busy), 32'd1);
        check("ar_grant_before", 32'(grant_id), 32'd1);
        #1 aresetn = 1'b0;
        #1;
        outputs_zero("ar");
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'h99;
        sample();
        check("late_rsp_ignored", 32'(rsp_valid), 32'd0);
        check("late_rsp_data", 32'(rsp_data), 32'd0);
        check("late_rsp_idle", 32'(arb_busy), 32'd0);
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;

        repeat (2) tick();
        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("rsp_count", 32'(rsp_cnt), 32'd2);
        check("timeout_total", 32'(to_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpu_cmd_arbiter.md
# dpu_cmd_arbiter

Multi-requester arbiter for the DPU core's byte-wide PIO command port (cmd_valid/ready/type/addr/data, rsp_valid/data). It grants the command port to one of NUM_REQ requesters (AXI-Lite PIO path, DMA engine, future layer sequencer) using round-robin. A grant is held across an outstanding read until its response returns, and across multi-beat bursts while the requester asserts lock. Each response is routed back to its originator, and a stalled read is recovered by timeout. It replaces the static busy-flag mux between the DMA and PIO paths in the system top.

## Interface
- NUM_REQ, 3: number of requesters (2..8); index 0 has top priority after reset
- ADDR_BITS, 24: command address width
- RD_CMD, 3'd2: cmd_type value that produces a response on the core's rsp_valid
- RSP_TIMEOUT, 255: cycles to wait for the core's response before abandoning (≥1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous assert, active-low (one clock; asynchronous active-low reset)
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accepted
- req_lock  in  NUM_REQ  keep grant after the current command
- req_type  in  NUM_REQ×3  command type
- req_addr  in  NUM_REQ×ADDR_BITS  command address
- req_data  in  NUM_REQ×8  write data
- rsp_valid  out  NUM_REQ  one-cycle response strobe to the originator
- rsp_data  out  8  response byte, shared by all requesters
- m_cmd_valid / m_cmd_ready  out / in  1  core command handshake
- m_cmd_type / m_cmd_addr / m_cmd_data  out  3 / ADDR_BITS / 8  granted payload
- m_rsp_valid / m_rsp_data  in  1 / 8  core response
- grant_id  out  $clog2(NUM_REQ)  current owner
- arb_busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on read timeout

## Operation
- States: IDLE, GRANT, WAIT_RSP.
- IDLE: when any req_valid is high, pick the first set bit starting at ptr and wrapping. Register grant_id and go to GRANT. ptr resets to 0.
- GRANT: m_cmd_* = payload of grant_id. m_cmd_valid = req_valid[grant_id]. req_ready[grant_id] = m_cmd_ready. All other req_ready bits are 0.
- On handshake (m_cmd_valid & m_cmd_ready):
  - if type == RD_CMD, go to WAIT_RSP and clear the timer;
  - else if req_lock[grant_id], stay in GRANT;
  - else go to IDLE with ptr = grant_id+1 mod NUM_REQ.
- GRANT with req_valid[grant_id]=0 and req_lock[grant_id]=0: release to IDLE and advance ptr. A locked owner holds the port indefinitely; that is the intended burst behaviour.
- WAIT_RSP: m_cmd_valid=0. On m_rsp_valid, pulse rsp_valid[grant_id] and drive rsp_data=m_rsp_data in the same cycle (combinational). Then go to GRANT if locked, else IDLE with ptr advanced.
- Timer reaching RSP_TIMEOUT without a response: pulse timeout_err, drive no rsp_valid, go to IDLE with ptr advanced.
- m_rsp_valid outside WAIT_RSP: ignored; no rsp_valid is produced.
- Response and timeout expiry in the same cycle: the response wins and no timeout_err is pulsed.
- grant_id changes only on the IDLE→GRANT transition.

## Timing
- Reset values: all outputs 0, grant_id=0, state IDLE, ptr=0, timer=0.
- Reset asserted mid-transaction aborts immediately. Any outstanding core response after reset is ignored.
- Arbitration latency: req_valid in cycle N gives m_cmd_valid in cycle N+1. The payload path is combinational from the granted requester.
- Back-to-back locked writes: one per cycle while m_cmd_ready=1.
- Unlocked release to the next grant: handshake cycle, then one IDLE cycle, then the new GRANT (2-cycle gap).
- Read response: rsp_valid asserts in the cycle m_rsp_valid asserts.
- Timeout: timeout_err asserts exactly RSP_TIMEOUT cycles after the read handshake.

## Structure
- Package dpu_arb_pkg holds the state enum (IDLE/GRANT/WAIT_RSP), the cmd-type localparams shared with the core, and the grant-index width function.
- Sub-module dpu_rr_picker: combinational rotating priority encoder. Inputs are the req vector and ptr. Outputs are the found flag and the index.
- Timer and ptr live in the arbiter.

## Test plan
- Single requester write: req 1 valid, type 3'd1, addr 0x000123, data 0xA5 → m_cmd mirrors it 1 cycle later; req_ready[1] pulses with m_cmd_ready; returns to IDLE.
- Round-robin: reqs 0, 1, 2 all continuously valid with unlocked writes → grant order 0,1,2,0,… with a 2-cycle gap between grants.
- Read routing: req 2 issues RD_CMD; core responds 0x3C after 5 cycles → rsp_valid[2] pulses once with rsp_data=0x3C; no other rsp_valid bit is set.
- Lock burst: req 1 locked with 16 writes while req 0 is valid → 16 consecutive req 1 handshakes; req 0 is granted only after lock drops.
- Timeout: RD_CMD with no response, RSP_TIMEOUT=8 → timeout_err pulses 8 cycles after the handshake; no rsp_valid; the next requester is then granted.
- Async reset mid-WAIT_RSP: drop aresetn → all outputs are 0 immediately; a late m_rsp_valid after reset produces no rsp_valid.
